// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master, one-slave Wishbone classic arbiter.
// Master 0 is the instruction-fetch path and master 1 is the data-cache path.
// The grant is registered and round-robin, and each grant covers exactly one
// single-beat transfer. After every transfer the arbiter spends one idle cycle.
// Optional feature: define WB_ARB_TIMEOUT_EN to enable the grant watchdog.
// The watchdog raises err to the granted master after TIMEOUT_CYCLES cycles
// without a slave termination.
//
// Handshake: a master's request is valid while mN_cyc_i & mN_stb_i. While that
// master is granted, its request is passed straight through to the slave. The
// transfer completes in the first cycle where any of wb_ack_i/wb_err_i/wb_rty_i
// is high, and that termination is routed to the granted master in the same
// cycle. A master may abandon its request by dropping cyc. In that case no
// response is routed.
module wb_arbiter_2m #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  // master 0 (instruction fetch)
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_cyc_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic                    m0_rty_o,
  // master 1 (data cache)
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_cyc_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    m1_rty_o,
  // slave side
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic                    wb_stb_o,
  output logic                    wb_cyc_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_rty_i,
  // one-hot current grant; 00 when idle
  output logic [1:0]              grant_o
);

  // Reject a watchdog limit the counter cannot represent.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_arbiter_2m: TIMEOUT_CYCLES must be within 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_gnt_q, last_gnt_d;   // master granted most recently

  logic req0, req1, term, to_hit;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  assign term = wb_ack_i | wb_err_i | wb_rty_i;

  // The read data bus is shared, so both masters always see the slave data.
  assign m0_dat_o = wb_dat_i;
  assign m1_dat_o = wb_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The watchdog fires only when the slave has not terminated in this cycle.
  // A real termination always wins over the watchdog.
  assign to_hit = (state_q != IDLE) && !term && (cnt_q == CW'(TIMEOUT_CYCLES));

  // Watchdog count: the count is zero on entry to a grant and advances while
  // the slave stalls.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!term && !to_hit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // Grant state and round-robin memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Arbitration, bus steering and response routing.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    wb_adr_o   = '0;
    wb_dat_o   = '0;
    wb_we_o    = 1'b0;
    wb_sel_o   = '0;
    wb_stb_o   = 1'b0;
    wb_cyc_o   = 1'b0;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m0_rty_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    m1_rty_o   = 1'b0;
    grant_o    = 2'b00;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          // On contention, the master that was not granted last wins.
          if (last_gnt_q) begin
            state_d    = GNT0;
            last_gnt_d = 1'b0;
          end else begin
            state_d    = GNT1;
            last_gnt_d = 1'b1;
          end
        end else if (req0) begin
          state_d    = GNT0;
          last_gnt_d = 1'b0;
        end else if (req1) begin
          state_d    = GNT1;
          last_gnt_d = 1'b1;
        end
      end
      GNT0: begin
        grant_o  = 2'b01;
        wb_adr_o = m0_adr_i;
        wb_dat_o = m0_dat_i;
        wb_we_o  = m0_we_i;
        wb_sel_o = m0_sel_i;
        wb_stb_o = m0_stb_i;
        wb_cyc_o = m0_cyc_i;
        m0_ack_o = wb_ack_i;
        m0_err_o = wb_err_i | to_hit;
        m0_rty_o = wb_rty_i;
        if (!m0_cyc_i || term || to_hit) begin
          state_d = IDLE;
        end
      end
      GNT1: begin
        grant_o  = 2'b10;
        wb_adr_o = m1_adr_i;
        wb_dat_o = m1_dat_i;
        wb_we_o  = m1_we_i;
        wb_sel_o = m1_sel_i;
        wb_stb_o = m1_stb_i;
        wb_cyc_o = m1_cyc_i;
        m1_ack_o = wb_ack_i;
        m1_err_o = wb_err_i | to_hit;
        m1_rty_o = wb_rty_i;
        if (!m1_cyc_i || term || to_hit) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Testbench for wb_arbiter_2m: scenario tasks plus a response scoreboard.
module tb_wb_arbiter_2m;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int W  = 1 + 3 + DW;   // {master, ack/err/rty, data}

  localparam logic [2:0] R_ACK = 3'b100;
  localparam logic [2:0] R_ERR = 3'b010;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [AW-1:0] m0_adr_i, m1_adr_i, wb_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, wb_dat_o, wb_dat_i;
  logic          m0_we_i, m1_we_i, wb_we_o;
  logic [SW-1:0] m0_sel_i, m1_sel_i, wb_sel_o;
  logic          m0_stb_i, m0_cyc_i, m1_stb_i, m1_cyc_i;
  logic          m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic          wb_stb_o, wb_cyc_o, wb_ack_i, wb_err_i, wb_rty_i;
  logic [1:0]    grant_o;

  // slave model: either zero-wait auto ack or manually driven terminations
  logic auto_ack, man_ack, man_err, man_rty;
  assign wb_ack_i = auto_ack ? (wb_cyc_o & wb_stb_o) : man_ack;
  assign wb_err_i = man_err;
  assign wb_rty_i = man_rty;

  wb_arbiter_2m #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .grant_o(grant_o)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // every master-side response is matched against the next expected entry
  always @(negedge clk) begin : monitor
    logic [W-1:0] obs;
    logic [W-1:0] exp_v;
    if (m0_ack_o || m0_err_o || m0_rty_o) begin
      obs = {1'b0, m0_ack_o, m0_err_o, m0_rty_o, m0_dat_o};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got %h want none", obs);
      end else begin
        exp_v = exp_q.pop_front();
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL resp_m0 got %h want %h", obs, exp_v);
        end
      end
    end
    if (m1_ack_o || m1_err_o || m1_rty_o) begin
      obs = {1'b1, m1_ack_o, m1_err_o, m1_rty_o, m1_dat_o};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got %h want none", obs);
      end else begin
        exp_v = exp_q.pop_front();
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL resp_m1 got %h want %h", obs, exp_v);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 1'b0; m0_sel_i = '0; m0_stb_i = 1'b0; m0_cyc_i = 1'b0;
    m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 1'b0; m1_sel_i = '0; m1_stb_i = 1'b0; m1_cyc_i = 1'b0;
    auto_ack = 1'b0; man_ack = 1'b0; man_err = 1'b0; man_rty = 1'b0;
    wb_dat_i = '0;
  endtask

  task automatic req_m0(input logic [AW-1:0] adr);
    m0_adr_i = adr; m0_we_i = 1'b0; m0_sel_i = 4'hF; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
  endtask

  task automatic req_m1(input logic [AW-1:0] adr, input logic we,
                        input logic [DW-1:0] dat, input logic [SW-1:0] sel);
    m1_adr_i = adr; m1_we_i = we; m1_dat_i = dat; m1_sel_i = sel;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
  endtask

  task automatic drop_m0();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
  endtask

  task automatic drop_m1();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    step();
    step();
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b00 || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_adr_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b cyc=%b stb=%b adr=%h want 00 0 0 0",
               grant_o, wb_cyc_o, wb_stb_o, wb_adr_o);
    end
    checks++;
    if ({m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_resp got %b want 000000",
               {m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o});
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    req_m0(32'h0000_1000);
    @(negedge clk);
    checks++;
    if (wb_stb_o !== 1'b0) begin
      errors++; $display("FAIL t1_stb_early got %b want 0", wb_stb_o);
    end
    step();   // GNT0, first wait cycle
    @(negedge clk);
    checks++;
    if (wb_stb_o !== 1'b1 || grant_o !== 2'b01 || wb_adr_o !== 32'h0000_1000) begin
      errors++;
      $display("FAIL t1_grant got stb=%b gnt=%b adr=%h want 1 01 00001000",
               wb_stb_o, grant_o, wb_adr_o);
    end
    step();   // second wait cycle
    @(negedge clk);
    checks++;
    if (m0_ack_o !== 1'b0) begin
      errors++; $display("FAIL t1_ack_early got %b want 0", m0_ack_o);
    end
    step();
    man_ack = 1'b1;
    wb_dat_i = 32'hDEAD_BEEF;
    exp_q.push_back({1'b0, R_ACK, 32'hDEAD_BEEF});
    @(negedge clk);
    checks++;
    if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hDEAD_BEEF || m1_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL t1_ack got ack0=%b dat=%h ack1=%b want 1 deadbeef 0",
               m0_ack_o, m0_dat_o, m1_ack_o);
    end
    step();
    man_ack = 1'b0;
    drop_m0();
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b00 || wb_cyc_o !== 1'b0) begin
      errors++; $display("FAIL t1_idle got gnt=%b cyc=%b want 00 0", grant_o, wb_cyc_o);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    logic          mb;
    rst = 1'b1;
    step();
    rst = 1'b0;
    auto_ack = 1'b1;
    req_m0(32'h0000_2000);
    req_m1(32'h0000_3000, 1'b1, 32'h1234_5678, 4'b0011);
    for (int i = 0; i < 8; i++) begin
      step();
      d = $urandom;
      wb_dat_i = d;
      mb = i[0];
      exp_q.push_back({mb, R_ACK, d});
      @(negedge clk);
      checks++;
      if (grant_o !== (mb ? 2'b10 : 2'b01) || wb_stb_o !== 1'b1) begin
        errors++;
        $display("FAIL t2_order[%0d] got gnt=%b stb=%b want %b 1", i, grant_o, wb_stb_o,
                 mb ? 2'b10 : 2'b01);
      end
      checks++;
      if (mb) begin
        if (wb_dat_o !== 32'h1234_5678 || wb_sel_o !== 4'b0011 || wb_we_o !== 1'b1 ||
            wb_adr_o !== 32'h0000_3000) begin
          errors++;
          $display("FAIL t2_m1_bus got dat=%h sel=%b we=%b adr=%h want 12345678 0011 1 00003000",
                   wb_dat_o, wb_sel_o, wb_we_o, wb_adr_o);
        end
      end else begin
        if (wb_adr_o !== 32'h0000_2000 || wb_we_o !== 1'b0) begin
          errors++;
          $display("FAIL t2_m0_bus got adr=%h we=%b want 00002000 0", wb_adr_o, wb_we_o);
        end
      end
      step();
      @(negedge clk);
      checks++;
      if (grant_o !== 2'b00 || wb_cyc_o !== 1'b0) begin
        errors++;
        $display("FAIL t2_idle[%0d] got gnt=%b cyc=%b want 00 0", i, grant_o, wb_cyc_o);
      end
    end
    drop_m0();
    drop_m1();
    auto_ack = 1'b0;
    step();
  endtask

  task automatic test_error();
    req_m1(32'h0000_4000, 1'b1, 32'hAAAA_5555, 4'hF);
    step();   // GNT1
    man_err = 1'b1;
    wb_dat_i = 32'h0000_0000;
    exp_q.push_back({1'b1, R_ERR, 32'h0000_0000});
    @(negedge clk);
    checks++;
    if (m1_err_o !== 1'b1 || m0_err_o !== 1'b0 || grant_o !== 2'b10) begin
      errors++;
      $display("FAIL t3_err got err1=%b err0=%b gnt=%b want 1 0 10", m1_err_o, m0_err_o, grant_o);
    end
    step();
    man_err = 1'b0;
    drop_m1();
    req_m0(32'h0000_5000);
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b00 || m1_err_o !== 1'b0) begin
      errors++; $display("FAIL t3_idle got gnt=%b err1=%b want 00 0", grant_o, m1_err_o);
    end
    step();
    man_ack = 1'b1;
    wb_dat_i = 32'hCAFE_F00D;
    exp_q.push_back({1'b0, R_ACK, 32'hCAFE_F00D});
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b01) begin
      errors++; $display("FAIL t3_next_grant got %b want 01", grant_o);
    end
    step();
    man_ack = 1'b0;
    drop_m0();
    step();
  endtask

  task automatic test_abort();
    req_m0(32'h0000_6000);
    step();   // GNT0
    req_m1(32'h0000_7000, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b01) begin
      errors++; $display("FAIL t4_grant0 got %b want 01", grant_o);
    end
    step();
    drop_m0();
    @(negedge clk);
    checks++;
    if (wb_cyc_o !== 1'b0 || m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL t4_abort got cyc=%b ack0=%b ack1=%b want 0 0 0", wb_cyc_o, m0_ack_o, m1_ack_o);
    end
    step();
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b00) begin
      errors++; $display("FAIL t4_idle got %b want 00", grant_o);
    end
    step();
    man_ack = 1'b1;
    wb_dat_i = 32'h1111_2222;
    exp_q.push_back({1'b1, R_ACK, 32'h1111_2222});
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b10 || wb_adr_o !== 32'h0000_7000) begin
      errors++;
      $display("FAIL t4_grant1 got gnt=%b adr=%h want 10 00007000", grant_o, wb_adr_o);
    end
    step();
    man_ack = 1'b0;
    drop_m1();
    step();
  endtask

  task automatic test_reset_mid();
    req_m1(32'h0000_8000, 1'b1, 32'h5A5A_5A5A, 4'hF);
    step();   // GNT1
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b10) begin
      errors++; $display("FAIL t5_grant1 got %b want 10", grant_o);
    end
    step();
    rst = 1'b1;
    step();   // reset taken at this edge
    rst = 1'b0;
    drop_m1();
    man_ack = 1'b1;   // late ack must not reach master 1
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b00 || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_adr_o !== '0 ||
        wb_dat_o !== '0 || wb_we_o !== 1'b0 || wb_sel_o !== '0) begin
      errors++;
      $display("FAIL t5_outputs got gnt=%b cyc=%b stb=%b adr=%h dat=%h we=%b sel=%b want all 0",
               grant_o, wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o);
    end
    checks++;
    if (m1_ack_o !== 1'b0 || m0_ack_o !== 1'b0) begin
      errors++; $display("FAIL t5_late_ack got ack1=%b ack0=%b want 0 0", m1_ack_o, m0_ack_o);
    end
    step();
    man_ack = 1'b0;
    req_m0(32'h0000_9000);
    req_m1(32'h0000_A000, 1'b0, 32'h0, 4'hF);
    step();
    man_ack = 1'b1;
    wb_dat_i = 32'h7777_0000;
    exp_q.push_back({1'b0, R_ACK, 32'h7777_0000});
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b01) begin
      errors++; $display("FAIL t5_first_contention got %b want 01", grant_o);
    end
    step();
    man_ack = 1'b0;
    drop_m0();
    drop_m1();
    step();
  endtask

  task automatic test_timeout();
    int hi_cnt;
    wb_dat_i = 32'h0BAD_0BAD;
    req_m0(32'h0000_B000);
    step();   // entry to GNT0
`ifdef WB_ARB_TIMEOUT_EN
    hi_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (m0_err_o !== 1'b0 || wb_cyc_o !== 1'b1) begin
        errors++;
        $display("FAIL t6_wait[%0d] got err=%b cyc=%b want 0 1", k, m0_err_o, wb_cyc_o);
      end
      step();
    end
    exp_q.push_back({1'b0, R_ERR, 32'h0BAD_0BAD});
    @(negedge clk);
    checks++;
    if (m0_err_o !== 1'b1) begin
      errors++; $display("FAIL t6_timeout_err got %b want 1", m0_err_o);
    end
    step();
    drop_m0();
    @(negedge clk);
    checks++;
    if (wb_cyc_o !== 1'b0 || grant_o !== 2'b00) begin
      errors++; $display("FAIL t6_cyc_fall got cyc=%b gnt=%b want 0 00", wb_cyc_o, grant_o);
    end
`else
    hi_cnt = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (wb_cyc_o === 1'b1 && m0_err_o === 1'b0) hi_cnt++;
      step();
    end
    checks++;
    if (hi_cnt != 120) begin
      errors++; $display("FAIL t6_hold got %0d cycles want 120", hi_cnt);
    end
    man_ack = 1'b1;
    exp_q.push_back({1'b0, R_ACK, 32'h0BAD_0BAD});
    @(negedge clk);
    checks++;
    if (m0_ack_o !== 1'b1) begin
      errors++; $display("FAIL t6_late_ack got %b want 1", m0_ack_o);
    end
    step();
    man_ack = 1'b0;
    drop_m0();
`endif
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_error();
    test_abort();
    test_reset_mid();
    test_timeout();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- global time bound ----------------
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation time bound exceeded");
  end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
Two-master, one-slave Wishbone classic arbiter. It shares the single external Wishbone port between the instruction-fetch path (master 0) and the data-cache path (master 1).
- Grants are registered and round-robin; a grant is held for exactly one single-beat transfer.
- Sits between the icache/dcache Wishbone master ports and the SoC bus/SRAM controller.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; select width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, watchdog limit in clk cycles (used only with the optional feature); legal range 1..65535.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mN_adr_i  in  ADDR_WIDTH  master N address (N = 0, 1, for every mN_ port).
- mN_dat_i  in  DATA_WIDTH  master N write data.
- mN_dat_o  out  DATA_WIDTH  master N read data.
- mN_we_i  in  1  master N write enable.
- mN_sel_i  in  DATA_WIDTH/8  master N byte select.
- mN_stb_i  in  1  master N strobe.
- mN_cyc_i  in  1  master N cycle.
- mN_ack_o  out  1  master N acknowledge.
- mN_err_o  out  1  master N error.
- mN_rty_o  out  1  master N retry.
- wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o  out  slave-side request.
- wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i  in  slave-side response.
- grant_o  out  2  one-hot current grant; 00 when idle.

Behaviour:
- Request definition: master N requests when mN_cyc_i & mN_stb_i.
- States:
  - IDLE: wb_cyc_o = wb_stb_o = 0; grant_o = 00.
  - GNT0: slave request signals mux from master 0.
  - GNT1: slave request signals mux from master 1.
- IDLE transitions:
  - Exactly one requester: go to that master's GNT state next cycle.
  - Both request: grant the master not in last_gnt, then update last_gnt.
  - last_gnt resets to 1, so master 0 wins the first contention.
- GNTn transitions:
  - Slave-side request signals are driven combinationally from master n.
  - wb_cyc_o/wb_stb_o equal mn_cyc_i/mn_stb_i.
- Termination: wb_ack_i | wb_err_i | wb_rty_i in GNTn:
  - Route ack/err/rty to master n the same cycle.
  - Return to IDLE next cycle.
  - One mandatory idle cycle follows every transfer, giving a deterministic 2-cycle turnaround.
- Abort: mn_cyc_i drops while in GNTn → IDLE next cycle; no response is routed.
- Response gating: mN_ack_o/err_o/rty_o are asserted only in GNTN, and are 0 in every other state.
- Read data: mN_dat_o = wb_dat_i for both masters, unconditionally.
- Latency: request in IDLE at cycle t → wb_stb_o at t+1. Earliest master-side ack is at t+1 for a zero-wait slave.
- A request arriving in IDLE during the post-transfer cycle is arbitrated normally. Back-to-back requests from one master while the other waits therefore alternate: 0,1,0,1.
- Multiple slave terminations asserted together: all are forwarded as-is; the arbiter takes no priority action.
- Reset (including mid-transfer):
  - State = IDLE, last_gnt = 1, timeout counter = 0.
  - All slave request outputs and master response outputs = 0; grant_o = 00.
  - Any transfer in flight is dropped silently.
- Address, data, we and sel toward the slave are 0 in IDLE.

Optional Feature:
Macro: WB_ARB_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to GNTn and increments each cycle in GNTn without a termination.
  - When the counter reaches TIMEOUT_CYCLES with no termination, mn_err_o is asserted for one cycle.
  - wb_cyc_o/wb_stb_o drop the next cycle and the state goes to IDLE.
  - A slave termination on the same cycle as timeout takes precedence; no extra err is generated.
- When undefined: no counter exists and a grant is held indefinitely until termination or abort.

Test Plan:
1. Single master 0 read at 0x0000_1000, slave acks after 2 waits with 0xDEADBEEF:
   - wb_stb_o rises 1 cycle after the request.
   - m0_ack_o with m0_dat_o = 0xDEADBEEF.
   - m1_ack_o stays 0.
   - grant_o = 01, then 00.
2. Both masters request continuously from reset, zero-wait slave:
   - Grant order 0,1,0,1.
   - Each transfer followed by exactly one IDLE cycle.
   - m1 write data 0x1234_5678 with sel = 0011 reaches the slave unchanged.
3. Master 1 write, slave returns wb_err_i:
   - m1_err_o pulses once.
   - State returns to IDLE; the next master 0 request is granted normally.
4. Master 0 drops cyc after 1 cycle in GNT0:
   - wb_cyc_o = 0 next cycle; no ack to either master.
   - A pending master 1 request is granted afterwards.
5. Assert rst while in GNT1 awaiting ack:
   - Next cycle all outputs are 0 and grant_o = 00.
   - A late wb_ack_i is not forwarded.
   - The first contention after reset grants master 0.
6. WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, slave never acks:
   - m0_err_o asserts 8 cycles after entry to GNT0.
   - wb_cyc_o falls the following cycle.
   - Without the macro, wb_cyc_o stays high for 100+ cycles.
